// File: rtl/mant_div_datapath_pkg.sv
// Shared FP divider constants and mantissa-divider FSM state encodings.
// Imported by the mantissa divider datapath, its interface and its sub-modules.
package mant_div_datapath_pkg;
   localparam int MANT_W = 24;
   localparam int ITERS  = 23;
   localparam int CNT_W  = $clog2(ITERS + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/mant_div_datapath_if.sv
// Control/operand/result bundle between the divider control FSM (master) and
// the mantissa divider datapath (slave).
interface mant_div_datapath_if;
   import mant_div_datapath_pkg::*;

   logic              in_load;
   logic              in_shift_en;
   logic [MANT_W-1:0] in_Dividend;
   logic [MANT_W-1:0] in_Divisor;
   logic [ITERS-1:0]  out_Quotient;
   logic              out_Sticky;
   logic              out_Valid;
   logic              out_Busy;
   logic              out_DivZero;
   logic              out_ProtoErr;

   modport master (
      output in_load, in_shift_en, in_Dividend, in_Divisor,
      input  out_Quotient, out_Sticky, out_Valid, out_Busy, out_DivZero, out_ProtoErr
   );

   modport slave (
      input  in_load, in_shift_en, in_Dividend, in_Divisor,
      output out_Quotient, out_Sticky, out_Valid, out_Busy, out_DivZero, out_ProtoErr
   );
endinterface

// File: rtl/mant_div_datapath_step.sv
// One restoring-division iteration: trial subtract, quotient bit, shifted remainder.
// Purely combinational.
module mant_div_step
   import mant_div_datapath_pkg::*;
(
   input  logic [MANT_W+1:0] i_rem,
   input  logic [MANT_W-1:0] i_div,
   output logic              o_qbit,
   output logic [MANT_W+1:0] o_rem
);
   logic [MANT_W+2:0] w_diff;
   logic [MANT_W+1:0] w_keep;

   // The extra top bit is the borrow; using it instead of the diff MSB keeps
   // the divide-by-zero case (remainder grows past 2^25) producing all ones.
   assign w_diff = {1'b0, i_rem} - {3'b000, i_div};
   assign o_qbit = ~w_diff[MANT_W+2];
   assign w_keep = o_qbit ? w_diff[MANT_W+1:0] : i_rem;
   assign o_rem  = w_keep << 1;
endmodule

// File: rtl/mant_div_datapath.sv
// Iterative restoring divider for 24-bit mantissas, one quotient bit per enabled cycle.
// Sequenced externally by load/shift pulses; flags shift pulses that arrive after completion.
module mant_div_datapath
   import mant_div_datapath_pkg::*;
(
   input  logic              in_Clk,
   input  logic              in_Rst_N,
   mant_div_datapath_if.slave bus
);
   state_t            r_state;
   state_t            w_next_state;
   logic [MANT_W+1:0] r_rem;
   logic [MANT_W-1:0] r_div;
   logic [ITERS-1:0]  r_q;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_div_zero;
   logic              r_proto_err;
   logic              w_qbit;
   logic [MANT_W+1:0] w_rem;
   logic              w_iter;
   logic              w_last;

   mant_div_step u_step (
      .i_rem  (r_rem),
      .i_div  (r_div),
      .o_qbit (w_qbit),
      .o_rem  (w_rem)
   );

   assign w_iter = !bus.in_load && bus.in_shift_en && (r_state == ST_RUN);
   assign w_last = (r_cnt == CNT_W'(ITERS - 1));

   always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      if (!in_Rst_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (bus.in_load) begin
         w_next_state = ST_RUN;
      end else if (w_iter && w_last) begin
         w_next_state = ST_DONE;
      end
   end

   always_comb begin
      bus.out_Valid = (r_state == ST_DONE);
      bus.out_Busy  = (r_state == ST_RUN);
   end

   always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      if (!in_Rst_N) begin
         r_rem       <= '0;
         r_div       <= '0;
         r_q         <= '0;
         r_cnt       <= '0;
         r_div_zero  <= 1'b0;
         r_proto_err <= 1'b0;
      end else if (bus.in_load) begin
         r_rem       <= {2'b00, bus.in_Dividend};
         r_div       <= bus.in_Divisor;
         r_q         <= '0;
         r_cnt       <= '0;
         r_div_zero  <= (bus.in_Divisor == '0);
         r_proto_err <= 1'b0;
      end else if (w_iter) begin
         r_rem <= w_rem;
         r_q   <= {r_q[ITERS-2:0], w_qbit};
         r_cnt <= r_cnt + CNT_W'(1);
      end else if (bus.in_shift_en && (r_state == ST_DONE)) begin
         r_proto_err <= 1'b1;
      end
   end

   assign bus.out_Quotient = r_q;
   assign bus.out_Sticky   = (r_rem != '0);
   assign bus.out_DivZero  = r_div_zero;
   assign bus.out_ProtoErr = r_proto_err;
endmodule

// File: tb/tb_mant_div_datapath.sv
// Bench for the mantissa divider: vector table through a result scoreboard,
// plus hand sequences for pause, protocol error, restart, reset and load/shift collision.
module tb_mant_div_datapath;
   import mant_div_datapath_pkg::*;

   typedef struct {
      logic [MANT_W-1:0] dvd;
      logic [MANT_W-1:0] dvs;
      logic [ITERS-1:0]  q;
      logic              sticky;
      logic              dz;
   } vec_t;

   typedef struct {
      logic [ITERS-1:0] q;
      logic             sticky;
      logic             dz;
   } exp_t;

   logic in_Clk;
   logic in_Rst_N;
   int   total;
   int   bad;
   exp_t sb[$];
   vec_t vecs[6];

   mant_div_datapath_if bus ();

   mant_div_datapath dut (
      .in_Clk   (in_Clk),
      .in_Rst_N (in_Rst_N),
      .bus      (bus)
   );

   initial in_Clk = 1'b0;
   always #5 in_Clk = ~in_Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge in_Clk);
      #1;
   endtask

   // Pop the oldest expectation when the DUT reports a completed result.
   task automatic collect(input string name);
      exp_t e;
      if (!bus.out_Valid) begin
         total++;
         bad++;
         $display("FAIL %s: no valid result within iteration budget, got valid=0 expected 1", name);
         if (sb.size() > 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: valid result with empty scoreboard, got q=%h expected none", name, bus.out_Quotient);
      end else begin
         e = sb.pop_front();
         chk({name, " q"},      32'(bus.out_Quotient), 32'(e.q));
         chk({name, " sticky"}, 32'(bus.out_Sticky),   32'(e.sticky));
         chk({name, " divzero"},32'(bus.out_DivZero),  32'(e.dz));
      end
   endtask

   // Load, then issue ITERS shift cycles with an optional pause; checks Valid timing.
   task automatic run_op(input string name, input vec_t v, input int pause_at,
                         input int pause_len, input logic shift_with_load);
      exp_t e;
      e.q = v.q; e.sticky = v.sticky; e.dz = v.dz;
      sb.push_back(e);
      bus.in_Dividend = v.dvd;
      bus.in_Divisor  = v.dvs;
      bus.in_load     = 1'b1;
      bus.in_shift_en = shift_with_load;
      tick();
      bus.in_load = 1'b0;
      chk({name, " busy after load"},  32'(bus.out_Busy), 32'd1);
      chk({name, " q clear after load"}, 32'(bus.out_Quotient), 32'd0);
      for (int i = 0; i < ITERS; i++) begin
         if (i == pause_at) begin
            bus.in_shift_en = 1'b0;
            for (int p = 0; p < pause_len; p++) begin
               tick();
               chk({name, " busy in pause"}, 32'(bus.out_Busy), 32'd1);
            end
         end
         bus.in_shift_en = 1'b1;
         tick();
         if (i == ITERS - 2) chk({name, " not valid early"}, 32'(bus.out_Valid), 32'd0);
      end
      bus.in_shift_en = 1'b0;
      chk({name, " busy clear"}, 32'(bus.out_Busy), 32'd0);
      collect(name);
   endtask

   initial begin
      vec_t one_one;
      logic [ITERS-1:0] held_q;
      logic saw_valid;
      total = 0;
      bad   = 0;
      vecs[0] = '{24'h800000, 24'h800000, 23'h400000, 1'b0, 1'b0};
      vecs[1] = '{24'h800000, 24'hC00000, 23'h2AAAAA, 1'b1, 1'b0};
      vecs[2] = '{24'hC00000, 24'h800000, 23'h600000, 1'b0, 1'b0};
      vecs[3] = '{24'h800000, 24'h000000, 23'h7FFFFF, 1'b0, 1'b1};
      vecs[4] = '{24'h000000, 24'h800000, 23'h000000, 1'b0, 1'b0};
      vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 23'h400000, 1'b0, 1'b0};
      one_one = vecs[0];

      in_Rst_N        = 1'b0;
      bus.in_load     = 1'b0;
      bus.in_shift_en = 1'b0;
      bus.in_Dividend = '0;
      bus.in_Divisor  = '0;
      #12;
      chk("reset valid",    32'(bus.out_Valid),    32'd0);
      chk("reset busy",     32'(bus.out_Busy),     32'd0);
      chk("reset quotient", 32'(bus.out_Quotient), 32'd0);
      chk("reset sticky",   32'(bus.out_Sticky),   32'd0);
      in_Rst_N = 1'b1;
      tick();

      // Shift pulses in IDLE do nothing and raise no error.
      bus.in_shift_en = 1'b1;
      tick(); tick();
      bus.in_shift_en = 1'b0;
      chk("idle shift protoerr", 32'(bus.out_ProtoErr), 32'd0);
      chk("idle shift quotient", 32'(bus.out_Quotient), 32'd0);

      for (int k = 0; k < 6; k++) begin
         run_op($sformatf("vec%0d", k), vecs[k], -1, 0, 1'b0);
      end

      run_op("pause", vecs[1], 10, 3, 1'b0);

      // Surplus shifts after completion: error flag, result frozen.
      held_q = bus.out_Quotient;
      bus.in_shift_en = 1'b1;
      tick(); tick();
      bus.in_shift_en = 1'b0;
      chk("protoerr set",       32'(bus.out_ProtoErr), 32'd1);
      chk("protoerr q held",    32'(bus.out_Quotient), 32'(held_q));
      chk("protoerr valid held",32'(bus.out_Valid),    32'd1);

      bus.in_Dividend = one_one.dvd;
      bus.in_Divisor  = one_one.dvs;
      bus.in_load     = 1'b1;
      tick();
      bus.in_load = 1'b0;
      chk("reload protoerr clear", 32'(bus.out_ProtoErr), 32'd0);
      chk("reload valid clear",    32'(bus.out_Valid),    32'd0);
      run_op("restart", one_one, -1, 0, 1'b0);

      // Load and shift together: the load cycle must not count as an iteration.
      run_op("load+shift", vecs[2], -1, 0, 1'b1);

      // Abort mid-run via async reset.
      bus.in_Dividend = vecs[1].dvd;
      bus.in_Divisor  = vecs[1].dvs;
      bus.in_load     = 1'b1;
      tick();
      bus.in_load     = 1'b0;
      bus.in_shift_en = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      in_Rst_N = 1'b0;
      #1;
      chk("midrun reset busy",     32'(bus.out_Busy),     32'd0);
      chk("midrun reset quotient", 32'(bus.out_Quotient), 32'd0);
      chk("midrun reset sticky",   32'(bus.out_Sticky),   32'd0);
      chk("midrun reset valid",    32'(bus.out_Valid),    32'd0);
      #10;
      in_Rst_N = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.out_Valid) saw_valid = 1'b1;
      end
      bus.in_shift_en = 1'b0;
      chk("no valid after reset", 32'(saw_valid),    32'd0);
      chk("no busy after reset",  32'(bus.out_Busy), 32'd0);

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard drain: got %0d leftover expected 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
